// File: rtl/reorder_buffer.sv
// reorder_buffer
//   Circular in-order reorder buffer. Each decoded instruction gets a tag (the
//   tail slot). Results arrive on the common data bus, and entries retire in
//   program order at a rate of one per cycle. When a retiring branch turns out
//   to be mispredicted, the buffer spends one cycle in FLUSH, pulses clear and
//   presents the corrected fetch PC.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   rdy                 global enable; low freezes all state
//   alloc_*             allocation request from decode
//   alloc_tag, rob_full granted tag (tail), allocation refused
//   cdb_*               result broadcast (tag, data, branch outcome/target)
//   q1_*, q2_*          dispatch operand look-ups (combinational)
//   commit_*            registered retire pulse to the register file
//   clear, redirect_pc  registered flush pulse and fetch target
module reorder_buffer #(
  parameter int DEPTH  = 16,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  input  logic              alloc_valid,
  input  logic              alloc_dest_valid,
  input  logic [REG_W-1:0]  alloc_dest,
  input  logic              alloc_is_branch,
  input  logic              alloc_pred_taken,
  output logic [TAG_W-1:0]  alloc_tag,
  output logic              rob_full,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              cdb_br_taken,
  input  logic [DATA_W-1:0] cdb_br_target,
  input  logic [TAG_W-1:0]  q1_tag,
  input  logic [TAG_W-1:0]  q2_tag,
  output logic              q1_ready,
  output logic              q2_ready,
  output logic [DATA_W-1:0] q1_data,
  output logic [DATA_W-1:0] q2_data,
  output logic              commit_valid,
  output logic [REG_W-1:0]  commit_reg_dest,
  output logic [TAG_W-1:0]  commit_tag,
  output logic [DATA_W-1:0] commit_data,
  output logic              clear,
  output logic [DATA_W-1:0] redirect_pc
);

  localparam logic [TAG_W:0] L_FULL = (TAG_W+1)'(DEPTH);

  typedef enum logic {S_RUN, S_FLUSH} state_t;

  state_t             r_state;
  state_t             w_state_next;

  // Control bits are reset; payload fields are only read while busy, so
  // they live in plain unreset storage.
  logic [DEPTH-1:0]   r_busy;
  logic [DEPTH-1:0]   r_ready;
  logic [DEPTH-1:0]   r_dest_valid;
  logic [DEPTH-1:0]   r_is_branch;
  logic [DEPTH-1:0]   r_pred_taken;
  logic [DEPTH-1:0]   r_br_taken;
  logic [REG_W-1:0]   r_dest   [DEPTH];
  logic [DATA_W-1:0]  r_data   [DEPTH];
  logic [DATA_W-1:0]  r_target [DEPTH];

  logic [TAG_W-1:0]   r_head;
  logic [TAG_W-1:0]   r_tail;
  logic [TAG_W:0]     r_count;
  logic [DATA_W-1:0]  r_flush_pc;

  logic               w_alloc;
  logic               w_wb;
  logic               w_commit;
  logic               w_mispredict;
  logic               w_flush_go;
  logic               w_q1_hit;
  logic               w_q2_hit;

  assign rob_full  = (r_count == L_FULL) || (r_state == S_FLUSH);
  assign alloc_tag = r_tail;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_RUN;
    else        r_state <= w_state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_RUN:   if (w_mispredict) w_state_next = S_FLUSH;
      S_FLUSH: if (rdy)          w_state_next = S_RUN;
      default: w_state_next = S_RUN;
    endcase
  end

  // ---------------- FSM: outputs / strobes ----------------
  // Commit looks at the registered ready bit, so a writeback landing on the
  // head in the same cycle only makes it eligible on the following cycle.
  always_comb begin
    w_alloc      = rdy && alloc_valid && !rob_full;
    w_wb         = rdy && (r_state == S_RUN) && cdb_valid && r_busy[cdb_tag];
    w_commit     = rdy && (r_state == S_RUN) && (r_count != '0) &&
                   r_busy[r_head] && r_ready[r_head];
    w_mispredict = w_commit && r_is_branch[r_head] &&
                   (r_br_taken[r_head] != r_pred_taken[r_head]);
    w_flush_go   = rdy && (r_state == S_FLUSH);
  end

  // ---------------- control state ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy          <= '0;
      r_ready         <= '0;
      r_head          <= '0;
      r_tail          <= '0;
      r_count         <= '0;
      r_flush_pc      <= '0;
      commit_valid    <= 1'b0;
      commit_reg_dest <= '0;
      commit_tag      <= '0;
      commit_data     <= '0;
      clear           <= 1'b0;
      redirect_pc     <= '0;
    end else begin
      commit_valid <= w_commit;
      clear        <= w_flush_go;
      if (w_flush_go) begin
        r_busy      <= '0;
        r_head      <= '0;
        r_tail      <= '0;
        r_count     <= '0;
        redirect_pc <= r_flush_pc;
      end else begin
        if (w_wb) r_ready[cdb_tag] <= 1'b1;
        if (w_commit) begin
          r_busy[r_head]  <= 1'b0;
          r_head          <= r_head + TAG_W'(1);
          commit_reg_dest <= r_dest_valid[r_head] ? r_dest[r_head] : '0;
          commit_tag      <= r_head;
          commit_data     <= r_data[r_head];
        end
        if (w_mispredict) r_flush_pc <= r_target[r_head];
        if (w_alloc) begin
          r_busy[r_tail]  <= 1'b1;
          r_ready[r_tail] <= 1'b0;
          r_tail          <= r_tail + TAG_W'(1);
        end
        unique case ({w_alloc, w_commit})
          2'b10:   r_count <= r_count + (TAG_W+1)'(1);
          2'b01:   r_count <= r_count - (TAG_W+1)'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // ---------------- entry payload ----------------
  always_ff @(posedge clk) begin
    if (w_alloc) begin
      r_dest_valid[r_tail] <= alloc_dest_valid;
      r_dest[r_tail]       <= alloc_dest;
      r_is_branch[r_tail]  <= alloc_is_branch;
      r_pred_taken[r_tail] <= alloc_pred_taken;
    end
    if (w_wb) begin
      r_data[cdb_tag]     <= cdb_data;
      r_br_taken[cdb_tag] <= cdb_br_taken;
      r_target[cdb_tag]   <= cdb_br_target;
    end
  end

  // ---------------- operand look-up ----------------
  // A stored result wins; otherwise forward a matching broadcast this cycle.
  assign w_q1_hit = r_busy[q1_tag] && r_ready[q1_tag];
  assign w_q2_hit = r_busy[q2_tag] && r_ready[q2_tag];

  assign q1_ready = w_q1_hit || (cdb_valid && (cdb_tag == q1_tag));
  assign q2_ready = w_q2_hit || (cdb_valid && (cdb_tag == q2_tag));
  assign q1_data  = w_q1_hit ? r_data[q1_tag] :
                    (cdb_valid && (cdb_tag == q1_tag)) ? cdb_data : '0;
  assign q2_data  = w_q2_hit ? r_data[q2_tag] :
                    (cdb_valid && (cdb_tag == q2_tag)) ? cdb_data : '0;

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

Circular in-order reorder buffer for the out-of-order core: allocates a tag per decoded instruction and captures execution results from the common data bus. Retires one instruction per cycle to the register file's `ROB_data_valid/ROB_reg_dest/ROB_tag/ROB_data` port. Serves operand look-ups from dispatch for tags the register file reports as busy. Flushes the pipeline through `clear` when a retiring branch was mispredicted.

## Interface
- `DEPTH`, 16: number of entries, power of two.
- `TAG_W`, 4: log2(DEPTH); width of tags (`TagBus`).
- `DATA_W`, 32: data / PC width (`DataBus`).
- `REG_W`, 5: architectural register index width (`RegBus`).
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `rdy` in 1: global enable; 0 freezes all state.
- `alloc_valid` in 1: ID requests an entry this cycle.
- `alloc_dest_valid` in 1: instruction writes a register.
- `alloc_dest` in REG_W: destination register.
- `alloc_is_branch` in 1: entry is a conditional branch.
- `alloc_pred_taken` in 1: predictor direction for the branch.
- `alloc_tag` out TAG_W: tag granted (combinational, = tail).
- `rob_full` out 1: allocation refused this cycle.
- `cdb_valid` in 1: result broadcast.
- `cdb_tag` in TAG_W: producing entry.
- `cdb_data` in DATA_W: result value.
- `cdb_br_taken` in 1: resolved branch direction.
- `cdb_br_target` in DATA_W: correct next PC for the branch.
- `q1_tag`, `q2_tag` in TAG_W: dispatch operand tags.
- `q1_ready`, `q2_ready` out 1: value available (combinational).
- `q1_data`, `q2_data` out DATA_W: value when ready, else 0.
- `commit_valid` out 1: retire pulse to regfile.
- `commit_reg_dest` out REG_W: 0 when no register write.
- `commit_tag` out TAG_W: tag of the retiring entry.
- `commit_data` out DATA_W: value of the retiring entry.
- `clear` out 1: one-cycle flush pulse to the whole core.
- `redirect_pc` out DATA_W: fetch target, valid while `clear`=1.

## Operation
- Per-entry state: busy, ready, dest_valid, dest, is_branch, pred_taken, br_taken, data, target. Pointers: `head`, `tail` (TAG_W, wrap modulo DEPTH) and `count` (TAG_W+1).
- FSM states: RUN and FLUSH.
- Allocate when `rdy && alloc_valid && !rob_full`:
  - set entry[tail] busy=1, ready=0, record the fields;
  - tail+1, count+1.
- `rob_full` = (count==DEPTH) || state==FLUSH. A same-cycle commit does not lower `rob_full`.
- Writeback when `cdb_valid` and entry[cdb_tag].busy: ready=1, data, br_taken, target. Writeback to a non-busy entry is ignored.
- Query port n: ready=1 and data=entry data if the entry is busy and ready. Otherwise, if `cdb_valid && cdb_tag==qn_tag`, ready=1 and data=`cdb_data`. Otherwise ready=0, data=0.
- Commit in RUN when count>0, entry[head].busy and entry[head].ready:
  - registered commit outputs; `commit_reg_dest`=dest when dest_valid, else 0;
  - clear busy, head+1, count-1.
- Mispredict: if the committed entry is a branch and br_taken != pred_taken, go to FLUSH.
- FLUSH lasts one cycle:
  - `clear`<=1, `redirect_pc`<=target;
  - all busy bits 0, head=tail=count=0, back to RUN.
  - No allocation or commit in FLUSH.
- The branch commit and `clear` land on successive edges, so the regfile applies the write before clear wipes its tags.

## Timing
- Reset (async, `rst_n`=0): all entries not busy, head=tail=count=0, state RUN. `commit_valid`=0, `commit_reg_dest`=0, `commit_tag`=0, `commit_data`=0, `clear`=0, `redirect_pc`=0. Combinational outputs follow the empty state: `rob_full`=0, `alloc_tag`=0, q*_ready=0.
- Earliest alloc to commit: allocate at edge N, CDB at N+1, ready visible after N+1, commit outputs at edge N+2.
- A writeback and a commit attempt on the same entry in the same cycle do not commit; the entry commits the next cycle.
- `commit_valid` and `clear` are single-cycle pulses, deasserted every other cycle.
- `rdy`=0: pointers, entries, FSM hold; `commit_valid` and `clear` go to 0.
- Simultaneous alloc and commit: count unchanged, both pointers advance.
- Wrap: tail 15 → 0 and head 15 → 0 are seamless.
- The full-to-empty distinction comes from `count`, never from pointer equality.

## Test plan
- Reset mid-run with count=5: drive `rst_n`=0 asynchronously → outputs 0 immediately, `rob_full`=0, next allocation gets tag 0.
- Alloc x1 tag 0, CDB tag0 data 0xDEADBEEF → commit_valid with reg 1, tag 0, data 0xDEADBEEF two edges after alloc. q1_tag=0 reads ready=1 with that data in the CDB cycle.
- Out-of-order completion: allocate tags 0,1,2; CDB order 2,1,0 → commits emitted in tag order 0,1,2 on consecutive cycles.
- Fill 16 entries → `rob_full`=1 and the 17th alloc is ignored. Commit one, allocate one → tag 0 reused (wrap).
- Branch with pred_taken=0 resolves taken, target 0x1000, followed by 3 younger entries → branch commit, next cycle `clear`=1 and `redirect_pc`=0x1000, then count=0; younger entries never commit.
- Hold `rdy`=0 for 3 cycles with a ready head → no commit and no state change; commit occurs on the first cycle after `rdy`=1.
